uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter ADDR_W, default 3, log2 of FIFO depth (8 entries).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port rdreq, input, 1, pop request from the memory stage.
REQ-007 SHALL have port clr_err, input, 1, one-cycle pulse clearing the error flags.
REQ-008 SHALL have port q, output, 8, registered read data fed to the memory stage's uart_in.
REQ-009 SHALL have port empty, output, 1, FIFO holds zero bytes.
REQ-010 SHALL have port full, output, 1, FIFO holds 2**ADDR_W bytes.
REQ-011 SHALL have port used, output, ADDR_W+1, current byte count.
REQ-012 SHALL have port frame_err, output, 1, sticky stop-bit error.
REQ-013 SHALL have port overrun_err, output, 1, sticky byte-dropped-on-full flag.

Function
REQ-014 SHALL pass rx through a two-flop synchronizer (reset value 1); the receiver SHALL use only the synchronized value.
REQ-015 SHALL implement receiver FSM states IDLE, START, DATA, STOP, using a baud counter of width clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-016 IDLE: a synchronized low SHALL enter START with the baud counter cleared.
REQ-017 START: after CLKS_PER_BIT/2 cycles, low SHALL go to DATA with the counter cleared; high (glitch) SHALL go back to IDLE with no push and no error.
REQ-018 DATA: every CLKS_PER_BIT cycles, SHALL sample one bit into the shift register, LSB first; after the 8th bit, SHALL go to STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles, SHALL sample the line and return to IDLE in the same cycle.
REQ-020 On a high stop sample with the FIFO not full, SHALL push the byte (wr_en for exactly one cycle).
REQ-021 On a high stop sample with the FIFO full and rdreq low, SHALL drop the byte and set overrun_err.
REQ-022 On a low stop sample, SHALL drop the byte, set frame_err and return to IDLE; a new start SHALL be detected only after rx reads high again.
REQ-023 FIFO read mode SHALL be normal (not show-ahead): rdreq high with empty low at edge N loads q with mem[rptr] and advances rptr; q SHALL be valid from cycle N+1 and SHALL hold until the next accepted pop.
REQ-024 rdreq while empty SHALL be ignored: q, pointers and used unchanged, no error.
REQ-025 Push and pop in the same cycle SHALL both take effect and leave used unchanged.
REQ-026 Push and pop in the same cycle while full SHALL both take effect with no overrun.
REQ-027 Push and pop in the same cycle while empty: the pop SHALL be ignored and the push SHALL occur.
REQ-028 Read and write pointers SHALL be ADDR_W bits and wrap modulo 2**ADDR_W.
REQ-029 used SHALL be an ADDR_W+1-bit counter.
REQ-030 empty SHALL be registered and equal (used==0).
REQ-031 full SHALL be registered and equal (used==2**ADDR_W).
REQ-032 frame_err and overrun_err SHALL be sticky until clr_err; if clr_err and a new error occur in the same cycle, the flag SHALL be set.

Reset
REQ-033 rst high SHALL immediately force FSM=IDLE, pointers=0, used=0, q=0, empty=1, full=0, both error flags=0, synchronizer=1, counters=0.
REQ-034 rst asserted mid-frame SHALL discard the partial byte; after release, reception SHALL resume only on the next start bit.
REQ-035 FIFO storage contents need no reset.

Verification
REQ-036 Scenario: CLKS_PER_BIT=16, send 0xA5 (8N1) -> exactly one push at the stop sample; empty falls; rdreq for 1 cycle -> q=0xA5 the next cycle, empty=1.
REQ-037 Scenario: send 9 bytes 0x00..0x08 with no reads -> full=1 after the 8th byte, used=8, overrun_err=1; 8 pops return 0x00..0x07 in order.
REQ-038 Scenario: send 0x3C with stop bit held low -> frame_err=1, no push, used=0; clr_err pulse -> frame_err=0.
REQ-039 Scenario: a 4-cycle low glitch on rx -> no push, FSM back in IDLE, no error flags set.
REQ-040 Scenario: FIFO full with rdreq high in the stop-sample cycle of byte 0x77 -> used stays 8, overrun_err=0, and 0x77 is read last.
REQ-041 Scenario: rst asserted during DATA bit 4 -> all outputs at reset values in the same cycle; the next complete byte 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding an 8-entry (2**ADDR_W) byte FIFO with normal-mode read.
// Sticky framing and overrun flags are cleared by a clr_err pulse.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              rdreq,
  input  logic              clr_err,
  output logic [7:0]        q,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   used,
  output logic              frame_err,
  output logic              overrun_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W:0]   DEPTH_U   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic              rx_meta_r;
  logic              rx_sync_r;
  state_t            state_r;
  logic [CNT_W-1:0]  baud_cnt_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
  logic              wait_high_r;

  logic [ADDR_W-1:0] wptr_r;
  logic [ADDR_W-1:0] rptr_r;
  logic [ADDR_W:0]   used_r;
  logic              empty_r;
  logic              full_r;
  logic [7:0]        q_r;
  logic              frame_err_r;
  logic              overrun_err_r;
  logic [7:0]        mem [DEPTH];

  logic              stop_tick_s;
  logic              push_s;
  logic              pop_s;
  logic              overrun_s;
  logic              frame_s;
  logic [ADDR_W:0]   used_next_s;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Stop-sample decode; a full FIFO still accepts a push when a pop frees a slot this cycle
  always_comb begin
    stop_tick_s = 1'b0;
    push_s      = 1'b0;
    overrun_s   = 1'b0;
    frame_s     = 1'b0;
    pop_s       = rdreq && !empty_r;
    if (state_r == STOP && baud_cnt_r == BIT_LAST) begin
      stop_tick_s = 1'b1;
    end else begin
      stop_tick_s = 1'b0;
    end
    if (stop_tick_s) begin
      push_s    = rx_sync_r && (!full_r || rdreq);
      overrun_s = rx_sync_r && full_r && !rdreq;
      frame_s   = !rx_sync_r;
    end else begin
      push_s    = 1'b0;
      overrun_s = 1'b0;
      frame_s   = 1'b0;
    end
    used_next_s = used_r + (ADDR_W + 1)'(push_s) - (ADDR_W + 1)'(pop_s);
  end

  // Receiver FSM; after a framing error the line must return high before a new start is armed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      baud_cnt_r  <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      wait_high_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          baud_cnt_r <= '0;
          bit_idx_r  <= 3'd0;
          if (wait_high_r) begin
            if (rx_sync_r) wait_high_r <= 1'b0;
          end else if (!rx_sync_r) begin
            state_r <= START;
          end
        end
        START: begin
          if (baud_cnt_r == HALF_LAST) begin
            baud_cnt_r <= '0;
            state_r    <= rx_sync_r ? IDLE : DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_cnt_r == BIT_LAST) begin
            baud_cnt_r <= '0;
            shift_r    <= {rx_sync_r, shift_r[7:1]};
            bit_idx_r  <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) state_r <= STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_cnt_r == BIT_LAST) begin
            baud_cnt_r <= '0;
            state_r    <= IDLE;
            if (!rx_sync_r) wait_high_r <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= '0;
        end
      endcase
    end
  end

  // FIFO storage, not reset
  always_ff @(posedge clk) begin
    if (push_s) mem[wptr_r] <= shift_r;
  end

  // FIFO pointers, occupancy, registered read data and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r        <= '0;
      rptr_r        <= '0;
      used_r        <= '0;
      empty_r       <= 1'b1;
      full_r        <= 1'b0;
      q_r           <= 8'h00;
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
    end else begin
      if (push_s) wptr_r <= wptr_r + ADDR_W'(1);
      if (pop_s) begin
        q_r    <= mem[rptr_r];
        rptr_r <= rptr_r + ADDR_W'(1);
      end
      used_r  <= used_next_s;
      empty_r <= (used_next_s == '0);
      full_r  <= (used_next_s == DEPTH_U);
      if (frame_s)      frame_err_r <= 1'b1;
      else if (clr_err) frame_err_r <= 1'b0;
      if (overrun_s)    overrun_err_r <= 1'b1;
      else if (clr_err) overrun_err_r <= 1'b0;
    end
  end

  assign q           = q_r;
  assign empty       = empty_r;
  assign full        = full_r;
  assign used        = used_r;
  assign frame_err   = frame_err_r;
  assign overrun_err = overrun_err_r;

endmodule
